// File: rtl/bus_wait_injector_pkg.sv
// Shared types and constants for the bus wait-state injector.
package bus_wait_pkg;

    // Per-channel transaction state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MODE_FIXED  = 0;
    localparam int MODE_RANDOM = 1;

    // Galois toggle mask for x^16+x^14+x^13+x^11+1, right-shifting form.
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/bus_wait_injector_if.sv
// Master-side and memory-side bus bundle for all channels of the injector.
interface bus_wait_injector_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // CPU master side
    logic [NUM_CH-1:0][ADDR_W-1:0]   m_address;
    logic [NUM_CH-1:0]               m_read;
    logic [NUM_CH-1:0]               m_write;
    logic [NUM_CH-1:0][DATA_W/8-1:0] m_byteenable;
    logic [NUM_CH-1:0][DATA_W-1:0]   m_wrdata;
    logic [NUM_CH-1:0][DATA_W-1:0]   m_rddata;
    logic [NUM_CH-1:0]               m_stall;
    // memory side
    logic [NUM_CH-1:0][ADDR_W-1:0]   s_address;
    logic [NUM_CH-1:0][DATA_W/8-1:0] s_byteenable;
    logic [NUM_CH-1:0][DATA_W-1:0]   s_wrdata;
    logic [NUM_CH-1:0]               s_read;
    logic [NUM_CH-1:0]               s_write;
    logic [NUM_CH-1:0][DATA_W-1:0]   s_rddata;

    // The injector: takes master requests, answers them, drives memory.
    modport slave (
        input  m_address, m_read, m_write, m_byteenable, m_wrdata, s_rddata,
        output m_rddata, m_stall, s_address, s_byteenable, s_wrdata, s_read, s_write
    );

    // The surroundings: CPU master ports plus the zero-latency memory.
    modport master (
        output m_address, m_read, m_write, m_byteenable, m_wrdata, s_rddata,
        input  m_rddata, m_stall, s_address, s_byteenable, s_wrdata, s_read, s_write
    );
endinterface

// File: rtl/bus_wait_injector_channel.sv
// One injector channel: IDLE/WAIT/DONE sequencer, request latches,
// protocol checks and completed-transaction counter.
module bus_wait_channel
    import bus_wait_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WAIT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WAIT_W-1:0]     wait_eff,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic [DATA_W-1:0]     wrdata,
    output logic [DATA_W-1:0]     rddata,
    output logic                  stall,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic [DATA_W-1:0]     mem_wrdata,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_W-1:0]     mem_rddata,
    output logic                  err_premature,
    output logic                  err_changed,
    output logic                  err_rw,
    output logic [31:0]           txn_count
);

    state_t                state;
    logic [WAIT_W-1:0]     cnt;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W/8-1:0]   be_q;
    logic [DATA_W-1:0]     data_q;
    logic                  is_wr_q;
    logic                  req;
    logic                  changed;
    logic                  in_idle;
    logic                  access;

    assign req     = read | write;
    assign in_idle = (state == IDLE);
    assign changed = (address != addr_q) || (byteenable != be_q) || (wrdata != data_q);
    assign stall   = req & (state != DONE);

    // A zero-wait access happens in the accepting IDLE cycle, so the memory
    // side shows the live request there and the latched copy afterwards.
    assign mem_address    = in_idle ? address    : addr_q;
    assign mem_byteenable = in_idle ? byteenable : be_q;
    assign mem_wrdata     = in_idle ? wrdata     : data_q;
    assign mem_read       = access & (in_idle ? read : ~is_wr_q);
    assign mem_write      = access & (in_idle ? (write & ~read) : is_wr_q);

    // Decide whether this cycle is the memory access cycle; reset kills it.
    always_comb begin
        access = 1'b0;
        if (!rst) begin
            if (state == IDLE)      access = req && (wait_eff == '0);
            else if (state == WAIT) access = req && (cnt == '0);
        end
    end

    // Transaction sequencer with latches, read-data capture, checks and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            addr_q        <= '0;
            be_q          <= '0;
            data_q        <= '0;
            is_wr_q       <= 1'b0;
            rddata        <= '0;
            err_premature <= 1'b0;
            err_changed   <= 1'b0;
            err_rw        <= 1'b0;
            txn_count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= address;
                        be_q    <= byteenable;
                        data_q  <= wrdata;
                        // read wins when both strobes are up
                        is_wr_q <= write & ~read;
                        if (read && write) err_rw <= 1'b1;
                        if (wait_eff == '0) begin
                            if (read) rddata <= mem_rddata;
                            state <= DONE;
                        end else begin
                            cnt   <= wait_eff - WAIT_W'(1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        err_premature <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        if (changed) err_changed <= 1'b1;
                        if (cnt == '0) begin
                            if (!is_wr_q) rddata <= mem_rddata;
                            state <= DONE;
                        end else begin
                            cnt <= cnt - WAIT_W'(1);
                        end
                    end
                end
                DONE: begin
                    txn_count <= txn_count + 32'd1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SIMULATION
    // Report protocol violations as they are detected.
    always @(posedge clk) begin
        if (!rst && state == IDLE && read && write)
            $display("%m: read and write asserted together");
        if (!rst && state == WAIT && !req)
            $display("%m: request dropped while stalled");
        else if (!rst && state == WAIT && changed)
            $display("%m: request changed while stalled");
    end
`endif

endmodule

// File: rtl/bus_wait_injector.sv
// Multi-channel wait-state injector: shared LFSR, per-channel wait clamp
// and randomisation, NUM_CH independent channel sequencers.
module bus_wait_injector
    import bus_wait_pkg::*;
#(
    parameter int          NUM_CH    = 2,
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter int          MAX_WAIT  = 15,
    parameter int          MODE      = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         WAIT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0][WAIT_W-1:0]  cfg_wait,
    bus_wait_injector_if.slave             bus,
    output logic [NUM_CH-1:0]              err_premature,
    output logic [NUM_CH-1:0]              err_changed,
    output logic [NUM_CH-1:0]              err_rw,
    output logic                           err_any,
    output logic [NUM_CH-1:0][31:0]        txn_count
);

    logic [15:0] lfsr;

    // Shared wait randomiser, advancing every non-reset cycle.
    always_ff @(posedge clk) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= lfsr_next(lfsr);
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [WAIT_W-1:0] clamp;
        logic [WAIT_W-1:0] w_eff;
        logic [7:0]        mix;

        // Clamp the configured wait and, in random mode, fold the LFSR
        // (salted per channel) into 0..clamp.
        always_comb begin
            clamp = (cfg_wait[c] > WAIT_W'(MAX_WAIT)) ? WAIT_W'(MAX_WAIT) : cfg_wait[c];
            mix   = lfsr[7:0] ^ 8'(c);
            if (MODE == MODE_RANDOM) w_eff = WAIT_W'(32'(mix) % (32'(clamp) + 32'd1));
            else                     w_eff = clamp;
        end

        bus_wait_channel #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .WAIT_W (WAIT_W)
        ) u_ch (
            .clk            (clk),
            .rst            (rst),
            .wait_eff       (w_eff),
            .address        (bus.m_address[c]),
            .read           (bus.m_read[c]),
            .write          (bus.m_write[c]),
            .byteenable     (bus.m_byteenable[c]),
            .wrdata         (bus.m_wrdata[c]),
            .rddata         (bus.m_rddata[c]),
            .stall          (bus.m_stall[c]),
            .mem_address    (bus.s_address[c]),
            .mem_byteenable (bus.s_byteenable[c]),
            .mem_wrdata     (bus.s_wrdata[c]),
            .mem_read       (bus.s_read[c]),
            .mem_write      (bus.s_write[c]),
            .mem_rddata     (bus.s_rddata[c]),
            .err_premature  (err_premature[c]),
            .err_changed    (err_changed[c]),
            .err_rw         (err_rw[c]),
            .txn_count      (txn_count[c])
        );
    end

    assign err_any = |{err_premature, err_changed, err_rw};

endmodule
